// File: rtl/rv_bp_pkg.sv
// Shared types for the fetch-stage branch predictor: direction-counter
// encodings, default table geometry and the BTB entry layout.
package rv_bp_pkg;

    localparam int unsigned BTB_ENTRIES = 16;
    localparam int unsigned BTB_IDX_W   = 4;
    // Sized for the smallest legal index so any IDX_W fits; unused upper bits stay zero.
    localparam int unsigned TAG_W       = 30;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_e;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        ctr_e             ctr;
    } btb_entry_t;

    function automatic ctr_e ctr_next(ctr_e c, logic taken);
        ctr_e n;
        n = c;
        case (c)
            SNT:     n = taken ? WNT : SNT;
            WNT:     n = taken ? WT  : SNT;
            WT:      n = taken ? ST  : WNT;
            ST:      n = taken ? ST  : WT;
            default: n = c;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: combinational lookup port plus
// update/allocation on resolved branches and jumps.
module bp_btb
    import rv_bp_pkg::*;
#(
    parameter int unsigned ENTRIES = BTB_ENTRIES,
    parameter int unsigned IDX_W   = BTB_IDX_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [29:0] rd_word,
    output logic        rd_taken,
    output logic [31:0] rd_target,
    input  logic        upd_en,
    input  logic [29:0] upd_word,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);

    btb_entry_t       entries_q [ENTRIES];
    btb_entry_t       entries_d [ENTRIES];
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [TAG_W-1:0] upd_tag;
    btb_entry_t       rd_e;
    btb_entry_t       upd_e;
    logic             rd_hit;
    logic             upd_hit;

    // Lookup reads the registered array, so a same-cycle update is not seen.
    always_comb begin
        rd_idx    = rd_word[IDX_W-1:0];
        rd_tag    = rd_word >> IDX_W;
        rd_e      = entries_q[rd_idx];
        rd_hit    = rd_e.valid && (rd_e.tag == rd_tag);
        rd_taken  = rd_hit && rd_e.ctr[1];
        rd_target = rd_e.target;
    end

    always_comb begin
        entries_d = entries_q;
        upd_idx   = upd_word[IDX_W-1:0];
        upd_tag   = upd_word >> IDX_W;
        upd_e     = entries_q[upd_idx];
        upd_hit   = upd_e.valid && (upd_e.tag == upd_tag);
        if (upd_en) begin
            if (upd_hit) begin
                entries_d[upd_idx].ctr = ctr_next(upd_e.ctr, upd_taken);
                if (upd_taken) begin
                    entries_d[upd_idx].target = upd_target;
                end
            end else if (upd_taken) begin
                entries_d[upd_idx] = '{valid: 1'b1, tag: upd_tag, target: upd_target, ctr: WT};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            entries_q <= entries_d;
        end
    end

endmodule

// File: rtl/fetch_predictor.sv
// Fetch PC generator: BTB-driven next-PC prediction, execute-stage
// misprediction detection with redirect, and saturating perf counters.
module fetch_predictor
    import rv_bp_pkg::*;
#(
    parameter int unsigned ENTRIES  = BTB_ENTRIES,
    parameter int unsigned IDX_W    = BTB_IDX_W,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             F_en,
    output logic [31:0]      F_pc,
    output logic             F_pred_taken,
    output logic [31:0]      F_pred_pc,
    input  logic             E_valid,
    input  logic             E_is_bj,
    input  logic [31:0]      E_pc,
    input  logic             E_taken,
    input  logic [31:0]      E_target,
    input  logic             E_pred_taken,
    input  logic [31:0]      E_pred_pc,
    output logic             branch_jump,
    output logic             mispre,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] bj_count,
    output logic [CNT_W-1:0] mispre_count
);

    logic [31:0]      pc_q;
    logic [31:0]      pc_d;
    logic [CNT_W-1:0] bj_count_q;
    logic [CNT_W-1:0] bj_count_d;
    logic [CNT_W-1:0] mispre_count_q;
    logic [CNT_W-1:0] mispre_count_d;
    logic             btb_taken;
    logic [31:0]      btb_target;

    bp_btb #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_btb (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_word    (pc_q[31:2]),
        .rd_taken   (btb_taken),
        .rd_target  (btb_target),
        .upd_en     (branch_jump),
        .upd_word   (E_pc[31:2]),
        .upd_taken  (E_taken),
        .upd_target (E_target)
    );

    always_comb begin
        F_pc         = pc_q;
        F_pred_taken = btb_taken;
        F_pred_pc    = btb_taken ? btb_target : pc_q + 32'd4;

        branch_jump = E_valid & E_is_bj;
        mispre      = branch_jump &
                      ((E_taken != E_pred_taken) | (E_taken & (E_target != E_pred_pc)));
        redirect_pc = E_taken ? E_target : E_pc + 32'd4;

        // A redirect wins even while the hazard unit is stalling fetch.
        if (mispre) begin
            pc_d = redirect_pc;
        end else if (F_en) begin
            pc_d = F_pred_pc;
        end else begin
            pc_d = pc_q;
        end

        bj_count_d     = bj_count_q;
        mispre_count_d = mispre_count_q;
        if (branch_jump && (bj_count_q != '1)) begin
            bj_count_d = bj_count_q + 1'b1;
        end
        if (mispre && (mispre_count_q != '1)) begin
            mispre_count_d = mispre_count_q + 1'b1;
        end

        bj_count     = bj_count_q;
        mispre_count = mispre_count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q           <= RESET_PC;
            bj_count_q     <= '0;
            mispre_count_q <= '0;
        end else begin
            pc_q           <= pc_d;
            bj_count_q     <= bj_count_d;
            mispre_count_q <= mispre_count_d;
        end
    end

endmodule

// File: tb/tb_fetch_predictor.sv
// Directed bench for fetch_predictor: a table-level reference model checked
// every cycle, plus hand-computed expectations along the scenario.
module tb_fetch_predictor;

    localparam int unsigned CW   = 4;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          F_en = 1'b0;
    logic [31:0]   F_pc;
    logic          F_pred_taken;
    logic [31:0]   F_pred_pc;
    logic          E_valid = 1'b0;
    logic          E_is_bj = 1'b0;
    logic [31:0]   E_pc = '0;
    logic          E_taken = 1'b0;
    logic [31:0]   E_target = '0;
    logic          E_pred_taken = 1'b0;
    logic [31:0]   E_pred_pc = '0;
    logic          branch_jump;
    logic          mispre;
    logic [31:0]   redirect_pc;
    logic [CW-1:0] bj_count;
    logic [CW-1:0] mispre_count;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_predictor #(
        .ENTRIES  (16),
        .IDX_W    (4),
        .RESET_PC (32'h0000_0000),
        .CNT_W    (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .F_en         (F_en),
        .F_pc         (F_pc),
        .F_pred_taken (F_pred_taken),
        .F_pred_pc    (F_pred_pc),
        .E_valid      (E_valid),
        .E_is_bj      (E_is_bj),
        .E_pc         (E_pc),
        .E_taken      (E_taken),
        .E_target     (E_target),
        .E_pred_taken (E_pred_taken),
        .E_pred_pc    (E_pred_pc),
        .branch_jump  (branch_jump),
        .mispre       (mispre),
        .redirect_pc  (redirect_pc),
        .bj_count     (bj_count),
        .mispre_count (mispre_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the table as plain arrays, indexed by word address mod 16.
    logic [31:0] m_pc;
    logic        m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    int          m_bj;
    int          m_misp;

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic logic m_hit(input logic [31:0] pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == pc / 64);
    endfunction

    function automatic logic m_ptaken(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_ppc(input logic [31:0] pc);
        return m_ptaken(pc) ? m_tgt[m_idx(pc)] : pc + 32'd4;
    endfunction

    function automatic logic m_exp_bj();
        return E_valid && E_is_bj;
    endfunction

    function automatic logic m_exp_mis();
        return m_exp_bj() && ((E_taken != E_pred_taken) || (E_taken && (E_target != E_pred_pc)));
    endfunction

    function automatic logic [31:0] m_exp_redir();
        return E_taken ? E_target : E_pc + 32'd4;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 32'h0;
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 1'b0;
                m_tag[i]   = '0;
                m_tgt[i]   = '0;
                m_ctr[i]   = 0;
            end
            m_bj   = 0;
            m_misp = 0;
        end else begin
            int k;
            logic bj;
            logic mis;
            bj  = m_exp_bj();
            mis = m_exp_mis();
            if (mis) m_pc = m_exp_redir();
            else if (F_en) m_pc = m_ppc(m_pc);
            if (bj) begin
                k = m_idx(E_pc);
                if (m_hit(E_pc)) begin
                    m_ctr[k] = E_taken ? ((m_ctr[k] < 3) ? m_ctr[k] + 1 : 3)
                                       : ((m_ctr[k] > 0) ? m_ctr[k] - 1 : 0);
                    if (E_taken) m_tgt[k] = E_target;
                end else if (E_taken) begin
                    m_valid[k] = 1'b1;
                    m_tag[k]   = E_pc / 64;
                    m_tgt[k]   = E_target;
                    m_ctr[k]   = 2;
                end
                if (m_bj < CMAX) m_bj++;
            end
            if (mis && m_misp < CMAX) m_misp++;
        end
    end

    always @(negedge clk) begin
        chk("cmp F_pc", F_pc, m_pc);
        chk("cmp F_pred_taken", {31'b0, F_pred_taken}, {31'b0, m_ptaken(m_pc)});
        chk("cmp F_pred_pc", F_pred_pc, m_ppc(m_pc));
        chk("cmp branch_jump", {31'b0, branch_jump}, {31'b0, m_exp_bj()});
        chk("cmp mispre", {31'b0, mispre}, {31'b0, m_exp_mis()});
        chk("cmp redirect_pc", redirect_pc, m_exp_redir());
        chk("cmp bj_count", 32'(bj_count), 32'(m_bj));
        chk("cmp mispre_count", 32'(mispre_count), 32'(m_misp));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_e();
        E_valid = 1'b0; E_is_bj = 1'b0; E_taken = 1'b0; E_pred_taken = 1'b0;
        E_pc = '0; E_target = '0; E_pred_pc = '0;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                           input logic ptaken, input logic [31:0] ppc);
        E_valid = 1'b1; E_is_bj = 1'b1; E_pc = pc; E_taken = taken;
        E_target = tgt; E_pred_taken = ptaken; E_pred_pc = ppc;
    endtask

    // Steer fetch to x with a mispredicted not-taken branch at x-4 (must miss the table).
    task automatic goto(input logic [31:0] x);
        resolve(x - 32'd4, 1'b0, 32'h0, 1'b1, x);
        step();
        clr_e();
        chk("goto F_pc", F_pc, x);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("reset F_pc", F_pc, 32'h0);
        chk("reset F_pred_taken", {31'b0, F_pred_taken}, 32'h0);
        chk("reset F_pred_pc", F_pred_pc, 32'h4);
        chk("reset bj_count", 32'(bj_count), 32'h0);
        chk("reset mispre_count", 32'(mispre_count), 32'h0);

        F_en = 1'b1;
        step(); chk("seq F_pc 4", F_pc, 32'h4);
        step(); chk("seq F_pc 8", F_pc, 32'h8);
        chk("seq pred not taken", {31'b0, F_pred_taken}, 32'h0);
        step(); step(); chk("seq F_pc 10", F_pc, 32'h10);

        resolve(32'h10, 1'b1, 32'h40, 1'b0, 32'h14);
        #1;
        chk("br mispre", {31'b0, mispre}, 32'h1);
        chk("br redirect", redirect_pc, 32'h40);
        chk("br branch_jump", {31'b0, branch_jump}, 32'h1);
        step(); clr_e();
        chk("br F_pc redirected", F_pc, 32'h40);
        goto(32'h10);
        chk("alloc pred taken", {31'b0, F_pred_taken}, 32'h1);
        chk("alloc pred pc", F_pred_pc, 32'h40);

        // Counter 2 -> 3 -> 3 -> 2
        resolve(32'h10, 1'b1, 32'h40, 1'b1, 32'h40);
        #1 chk("ctr correct pred", {31'b0, mispre}, 32'h0);
        step();
        resolve(32'h10, 1'b1, 32'h40, 1'b1, 32'h40);
        step();
        resolve(32'h10, 1'b0, 32'h0, 1'b0, 32'h14);
        #1 chk("ctr nt no mispre", {31'b0, mispre}, 32'h0);
        step(); clr_e();
        goto(32'h10);
        chk("ctr 2 still taken", {31'b0, F_pred_taken}, 32'h1);

        resolve(32'h10, 1'b0, 32'h0, 1'b0, 32'h14);
        #1 chk("read before write", {31'b0, F_pred_taken}, 32'h1);
        step(); clr_e();
        chk("rbw next pc", F_pc, 32'h40);
        goto(32'h10);
        chk("ctr 1 not taken", {31'b0, F_pred_taken}, 32'h0);
        chk("ctr 1 pred pc", F_pred_pc, 32'h14);

        F_en = 1'b0;
        resolve(32'h20, 1'b1, 32'h60, 1'b0, 32'h24);
        step(); clr_e();
        chk("stall redirect", F_pc, 32'h60);
        step();
        chk("stall hold", F_pc, 32'h60);
        F_en = 1'b1;

        resolve(32'h10, 1'b1, 32'h84, 1'b1, 32'h80);
        #1;
        chk("jalr mispre", {31'b0, mispre}, 32'h1);
        chk("jalr redirect", redirect_pc, 32'h84);
        step(); clr_e();
        chk("jalr F_pc", F_pc, 32'h84);
        goto(32'h10);
        chk("jalr pred taken", {31'b0, F_pred_taken}, 32'h1);
        chk("jalr new target", F_pred_pc, 32'h84);

        rst_n = 1'b0;
        #1;
        chk("async reset F_pc", F_pc, 32'h0);
        chk("async reset bj_count", 32'(bj_count), 32'h0);
        step();
        rst_n = 1'b1;

        resolve(32'h10, 1'b1, 32'h40, 1'b0, 32'h14);
        step();
        resolve(32'h50, 1'b1, 32'h90, 1'b0, 32'h54);
        step(); clr_e();
        chk("alias bj_count", 32'(bj_count), 32'h2);
        chk("alias mispre_count", 32'(mispre_count), 32'h2);
        goto(32'h10);
        chk("alias 10 miss", {31'b0, F_pred_taken}, 32'h0);
        chk("alias 10 pred pc", F_pred_pc, 32'h14);
        goto(32'h50);
        chk("alias 50 hit", {31'b0, F_pred_taken}, 32'h1);
        chk("alias 50 target", F_pred_pc, 32'h90);

        for (int i = 0; i < 14; i++) begin
            resolve(32'h3C, 1'b0, 32'h0, 1'b1, 32'h40);
            step();
        end
        clr_e();
        chk("sat bj_count", 32'(bj_count), 32'(CMAX));
        chk("sat mispre_count", 32'(mispre_count), 32'(CMAX));
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
